// File: rtl/msu_sector_streamer.sv
// Streams a byte-sized audio track from 512-byte sectors into a sample FIFO,
// with fill-level throttling of sector requests, loop-point wrap and stop/restart.
module msu_sector_streamer #(
    parameter int LBA_W     = 21,
    parameter int SECT_LOG2 = 8,
    parameter int USEDW_W   = 12,
    parameter int HIGH_MARK = 1792
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               play,
    input  logic               stop,
    input  logic               repeat_en,
    input  logic [31:0]        img_size,
    input  logic [31:0]        loop_word,
    input  logic               sd_ack,
    input  logic               sd_buff_wr,
    input  logic [15:0]        sd_buff_dout,
    input  logic [USEDW_W-1:0] fifo_usedw,
    output logic               sd_rd,
    output logic [LBA_W-1:0]   sd_lba,
    output logic               fifo_wr,
    output logic [15:0]        fifo_data,
    output logic               playing,
    output logic               looped,
    output logic               done
);

    typedef enum logic [2:0] {IDLE, REQ, XFER, NEXT, END, DRAIN} state_t;

    localparam logic [SECT_LOG2-1:0] MASK = '1;
    localparam logic [USEDW_W-1:0]   HIGH = USEDW_W'(HIGH_MARK);

    state_t               r_state, w_state_n;
    logic                 r_sd_rd, w_sd_rd_n;
    logic [LBA_W-1:0]     r_lba, w_lba_n;
    logic                 r_fifo_wr, w_fifo_wr_n;
    logic [15:0]          r_fifo_data, w_fifo_data_n;
    logic                 r_playing, w_playing_n;
    logic                 r_looped, w_looped_n;
    logic                 r_done, w_done_n;
    logic [SECT_LOG2:0]   r_cnt, w_cnt_n;
    logic [SECT_LOG2-1:0] r_start_off, w_start_off_n;
    logic                 r_restart, w_restart_n;

    logic                 r_tw_zero;
    logic [LBA_W-1:0]     r_end_lba, r_loop_lba;
    logic [SECT_LOG2-1:0] r_end_off, r_loop_off;

    logic [31:0]          w_tw, w_last;
    logic                 w_tw_zero, w_loop_ok;
    logic [LBA_W-1:0]     w_end_lba, w_loop_lba;
    logic [SECT_LOG2-1:0] w_end_off, w_loop_off, w_idx, w_stop_off;
    logic                 w_go, w_abort, w_in_win;

    assign w_tw       = img_size >> 1;
    assign w_last     = w_tw - 32'd1;
    assign w_tw_zero  = (w_tw == 32'd0);
    assign w_end_lba  = LBA_W'(w_last >> SECT_LOG2);
    assign w_end_off  = w_last[SECT_LOG2-1:0];
    assign w_loop_ok  = (loop_word < w_tw);
    assign w_loop_lba = w_loop_ok ? LBA_W'(loop_word >> SECT_LOG2) : '0;
    assign w_loop_off = w_loop_ok ? loop_word[SECT_LOG2-1:0] : '0;

    // play together with stop counts as stop only
    assign w_go    = play & ~stop;
    assign w_abort = play | stop;

    assign w_idx      = r_cnt[SECT_LOG2-1:0];
    assign w_stop_off = (r_lba == r_end_lba) ? r_end_off : MASK;
    assign w_in_win   = (w_idx >= r_start_off) && (w_idx <= w_stop_off);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tw_zero  <= 1'b1;
            r_end_lba  <= '0;
            r_end_off  <= '0;
            r_loop_lba <= '0;
            r_loop_off <= '0;
        end else if (w_go) begin
            r_tw_zero  <= w_tw_zero;
            r_end_lba  <= w_end_lba;
            r_end_off  <= w_end_off;
            r_loop_lba <= w_loop_lba;
            r_loop_off <= w_loop_off;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_sd_rd     <= 1'b0;
            r_lba       <= '0;
            r_fifo_wr   <= 1'b0;
            r_fifo_data <= '0;
            r_playing   <= 1'b0;
            r_looped    <= 1'b0;
            r_done      <= 1'b0;
            r_cnt       <= '0;
            r_start_off <= '0;
            r_restart   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_sd_rd     <= w_sd_rd_n;
            r_lba       <= w_lba_n;
            r_fifo_wr   <= w_fifo_wr_n;
            r_fifo_data <= w_fifo_data_n;
            r_playing   <= w_playing_n;
            r_looped    <= w_looped_n;
            r_done      <= w_done_n;
            r_cnt       <= w_cnt_n;
            r_start_off <= w_start_off_n;
            r_restart   <= w_restart_n;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_sd_rd_n     = r_sd_rd;
        w_lba_n       = r_lba;
        w_fifo_wr_n   = 1'b0;
        w_fifo_data_n = r_fifo_data;
        w_playing_n   = r_playing;
        w_looped_n    = 1'b0;
        w_done_n      = 1'b0;
        w_cnt_n       = r_cnt;
        w_start_off_n = r_start_off;
        w_restart_n   = r_restart;
        case (r_state)
            IDLE: begin
                w_restart_n = 1'b0;
                // a restart pending from an abort uses the values captured with that play
                if (w_go || (r_restart && !stop)) begin
                    if (w_go ? w_tw_zero : r_tw_zero) begin
                        w_done_n = 1'b1;
                    end else begin
                        w_lba_n       = '0;
                        w_start_off_n = '0;
                        w_playing_n   = 1'b1;
                        w_state_n     = REQ;
                    end
                end
            end
            REQ: begin
                if (w_abort) begin
                    w_sd_rd_n   = 1'b0;
                    w_playing_n = 1'b0;
                    w_restart_n = w_go;
                    w_state_n   = IDLE;
                end else if (r_sd_rd) begin
                    if (sd_ack) begin
                        w_sd_rd_n = 1'b0;
                        w_cnt_n   = '0;
                        w_state_n = XFER;
                    end
                end else if (fifo_usedw < HIGH) begin
                    w_sd_rd_n = 1'b1;
                end
            end
            XFER: begin
                if (w_abort) begin
                    w_restart_n = w_go;
                    w_state_n   = DRAIN;
                end else if (!sd_ack) begin
                    w_state_n = NEXT;
                end else if (sd_buff_wr && !r_cnt[SECT_LOG2]) begin
                    w_cnt_n = r_cnt + 1'b1;
                    if (w_in_win) begin
                        w_fifo_wr_n   = 1'b1;
                        w_fifo_data_n = sd_buff_dout;
                    end
                end
            end
            NEXT: begin
                if (w_abort) begin
                    w_playing_n = 1'b0;
                    w_restart_n = w_go;
                    w_state_n   = IDLE;
                end else if (r_lba < r_end_lba) begin
                    w_lba_n       = r_lba + 1'b1;
                    w_start_off_n = '0;
                    w_state_n     = REQ;
                end else begin
                    w_state_n = END;
                end
            end
            END: begin
                if (w_abort) begin
                    w_playing_n = 1'b0;
                    w_restart_n = w_go;
                    w_state_n   = IDLE;
                end else if (repeat_en) begin
                    w_lba_n       = r_loop_lba;
                    w_start_off_n = r_loop_off;
                    w_looped_n    = 1'b1;
                    w_state_n     = REQ;
                end else begin
                    w_done_n    = 1'b1;
                    w_playing_n = 1'b0;
                    w_lba_n     = '0;
                    w_state_n   = IDLE;
                end
            end
            DRAIN: begin
                if (w_go) begin
                    w_restart_n = 1'b1;
                end else if (stop) begin
                    w_restart_n = 1'b0;
                end
                if (!sd_ack) begin
                    w_playing_n = 1'b0;
                    w_state_n   = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    assign sd_rd     = r_sd_rd;
    assign sd_lba    = r_lba;
    assign fifo_wr   = r_fifo_wr;
    assign fifo_data = r_fifo_data;
    assign playing   = r_playing;
    assign looped    = r_looped;
    assign done      = r_done;

endmodule

// File: tb/tb_msu_sector_streamer.sv
// Directed bench for msu_sector_streamer: a sector server drives the SD side,
// a word-level model of the track predicts the FIFO stream checked every cycle.
module tb_msu_sector_streamer;

    logic        clk = 1'b0;
    logic        reset, play, stop, repeat_en;
    logic [31:0] img_size, loop_word;
    logic        sd_ack, sd_buff_wr;
    logic [15:0] sd_buff_dout;
    logic [11:0] fifo_usedw;
    logic        sd_rd, fifo_wr, playing, looped, done;
    logic [20:0] sd_lba;
    logic [15:0] fifo_data;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int looped_cnt = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    msu_sector_streamer dut (
        .clk(clk), .reset(reset), .play(play), .stop(stop), .repeat_en(repeat_en),
        .img_size(img_size), .loop_word(loop_word), .sd_ack(sd_ack),
        .sd_buff_wr(sd_buff_wr), .sd_buff_dout(sd_buff_dout), .fifo_usedw(fifo_usedw),
        .sd_rd(sd_rd), .sd_lba(sd_lba), .fifo_wr(fifo_wr), .fifo_data(fifo_data),
        .playing(playing), .looped(looped), .done(done)
    );

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic logic [15:0] pat(input int lba, input int idx);
        return 16'((((lba & 255) ^ 165) << 8) | (idx & 255));
    endfunction

    // Track model: word w of the image lives in sector w/256 at offset w%256.
    task automatic model_range(input int from_w, input int to_w);
        for (int w = from_w; w < to_w; w++) exp_q.push_back(pat(w / 256, w % 256));
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (fifo_wr) begin
                wr_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL fifo_wr_unexpected: fifo_wr=1 data=%h, required no write", fifo_data);
                end else begin
                    check("fifo_data", fifo_data, exp_q.pop_front());
                end
            end
            if (done) done_cnt++;
            if (looped) looped_cnt++;
            if (done || looped) check("done_looped_exclusive", done & looped, 0);
        end
    end

    task automatic wait_rd(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sd_rd && n < 60);
        if (!sd_rd) check(name, sd_rd, 1);
    endtask

    task automatic serve(output int lba, input int stop_at, input int rst_at);
        lba = -1;
        wait_rd("sd_rd_timeout");
        if (!sd_rd) return;
        lba = int'(sd_lba);
        @(posedge clk); #1 sd_ack = 1'b1;
        @(posedge clk); #1;
        check("sd_rd_drop_after_ack", sd_rd, 0);
        for (int i = 0; i < 256; i++) begin
            if (i == rst_at) begin
                sd_buff_wr = 1'b0;
                @(negedge clk); #2 reset = 1'b1;
                #1;
                check("rst_sd_rd", sd_rd, 0);
                check("rst_sd_lba", sd_lba, 0);
                check("rst_fifo_wr", fifo_wr, 0);
                check("rst_fifo_data", fifo_data, 0);
                check("rst_playing", playing, 0);
                check("rst_looped", looped, 0);
                check("rst_done", done, 0);
                sd_ack = 1'b0;
                @(posedge clk); #1 reset = 1'b0;
                return;
            end
            sd_buff_wr   = 1'b1;
            sd_buff_dout = pat(lba, i);
            stop         = (i == stop_at);
            @(posedge clk); #1;
        end
        sd_buff_wr = 1'b0;
        stop       = 1'b0;
        sd_ack     = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_play();
        @(posedge clk); #1 play = 1'b1;
        @(posedge clk); #1 play = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
    endtask

    initial begin
        int l, w0, d0, lp0, n;
        reset = 1'b0; play = 1'b0; stop = 1'b0; repeat_en = 1'b0;
        img_size = 0; loop_word = 0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
        sd_buff_dout = 0; fifo_usedw = 0;
        #1 reset = 1'b1;
        #1;
        check("reset_sd_rd", sd_rd, 0);
        check("reset_sd_lba", sd_lba, 0);
        check("reset_fifo_wr", fifo_wr, 0);
        check("reset_playing", playing, 0);
        check("reset_looped", looped, 0);
        check("reset_done", done, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // two full sectors, no repeat
        img_size = 1024; w0 = wr_cnt; d0 = done_cnt;
        model_range(0, 512);
        pulse_play();
        check("t1_playing", playing, 1);
        serve(l, -1, -1); check("t1_lba_first", l, 0);
        serve(l, -1, -1); check("t1_lba_second", l, 1);
        repeat (10) @(posedge clk); #1;
        check("t1_wr_count", wr_cnt - w0, 512);
        check("t1_done_count", done_cnt - d0, 1);
        check("t1_playing_end", playing, 0);
        check("t1_queue_left", exp_q.size(), 0);

        // partial last sector
        img_size = 1028; w0 = wr_cnt; d0 = done_cnt;
        model_range(0, 514);
        pulse_play();
        serve(l, -1, -1); check("t2_lba0", l, 0);
        serve(l, -1, -1); check("t2_lba1", l, 1);
        serve(l, -1, -1); check("t2_lba2", l, 2);
        repeat (10) @(posedge clk); #1;
        check("t2_wr_count", wr_cnt - w0, 514);
        check("t2_done_count", done_cnt - d0, 1);
        check("t2_queue_left", exp_q.size(), 0);

        // loop back to word 300 (sector 1, offset 44)
        img_size = 1024; repeat_en = 1'b1; loop_word = 300;
        w0 = wr_cnt; d0 = done_cnt; lp0 = looped_cnt;
        model_range(0, 512);
        pulse_play();
        serve(l, -1, -1); check("t3_lba0", l, 0);
        serve(l, -1, -1); check("t3_lba1", l, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!looped && n < 10);
        check("t3_looped_pulse", looped, 1);
        check("t3_lba_at_loop", sd_lba, 1);
        model_range(300, 512);
        serve(l, -1, -1); check("t3_loop_lba", l, 1);
        wait_rd("t3_second_loop_rd");
        pulse_stop();
        repeat (3) @(posedge clk); #1;
        check("t3_wr_count", wr_cnt - w0, 724);
        check("t3_looped_count", looped_cnt - lp0, 2);
        check("t3_no_done", done_cnt - d0, 0);
        check("t3_playing_after_stop", playing, 0);
        check("t3_sd_rd_after_stop", sd_rd, 0);
        check("t3_queue_left", exp_q.size(), 0);
        repeat_en = 1'b0; loop_word = 0;

        // fill-level throttle, then stop in REQ
        fifo_usedw = 12'd1792; d0 = done_cnt;
        pulse_play();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_rd_held_off", sd_rd, 0);
        end
        @(posedge clk); #1 fifo_usedw = 12'd1791;
        @(negedge clk); check("t4_rd_not_yet", sd_rd, 0);
        @(negedge clk); check("t4_rd_below_mark", sd_rd, 1);
        pulse_stop();
        check("t4_rd_dropped", sd_rd, 0);
        check("t4_playing_dropped", playing, 0);
        repeat (3) @(posedge clk); #1;
        check("t4_rd_idle", sd_rd, 0);
        check("t4_no_done", done_cnt - d0, 0);
        fifo_usedw = 0;

        // stop at word 100 of sector 0
        img_size = 1024; w0 = wr_cnt; d0 = done_cnt;
        model_range(0, 100);
        pulse_play();
        serve(l, 100, -1); check("t5_lba0", l, 0);
        repeat (5) @(posedge clk); #1;
        check("t5_wr_count", wr_cnt - w0, 100);
        check("t5_playing", playing, 0);
        check("t5_sd_rd_idle", sd_rd, 0);
        check("t5_no_done", done_cnt - d0, 0);
        check("t5_queue_left", exp_q.size(), 0);

        // reset in the middle of sector 1, then replay from lba 0
        w0 = wr_cnt;
        model_range(0, 306);
        pulse_play();
        serve(l, -1, -1); check("t6_lba0", l, 0);
        serve(l, -1, 50); check("t6_lba1", l, 1);
        repeat (5) @(posedge clk); #1;
        check("t6_wr_before_reset", wr_cnt - w0, 306);
        check("t6_sd_rd_after_reset", sd_rd, 0);
        w0 = wr_cnt; d0 = done_cnt;
        model_range(0, 512);
        pulse_play();
        serve(l, -1, -1); check("t6_restart_lba0", l, 0);
        serve(l, -1, -1); check("t6_restart_lba1", l, 1);
        repeat (10) @(posedge clk); #1;
        check("t6_wr_count", wr_cnt - w0, 512);
        check("t6_done_count", done_cnt - d0, 1);
        check("t6_queue_left", exp_q.size(), 0);

        // one-byte track: no whole word, immediate done
        img_size = 1; d0 = done_cnt; w0 = wr_cnt;
        pulse_play();
        repeat (3) @(posedge clk); #1;
        check("t7_done_count", done_cnt - d0, 1);
        check("t7_playing", playing, 0);
        check("t7_sd_rd", sd_rd, 0);
        check("t7_no_writes", wr_cnt - w0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/msu_sector_streamer.md
MSU_SECTOR_STREAMER -- requirements
Module: msu_sector_streamer

Interface
REQ-001 The block SHALL have parameter LBA_W, default 21, meaning width of the sector address.
REQ-002 The block SHALL have parameter SECT_LOG2, default 8, meaning log2 of 16-bit words per sector (256 words = 512 bytes).
REQ-003 The block SHALL have parameter USEDW_W, default 12, meaning width of the audio FIFO fill level.
REQ-004 The block SHALL have parameter HIGH_MARK, default 1792, meaning the FIFO fill level at or above which no new sector is requested.
REQ-005 The block SHALL have one clock and asynchronous, active-high reset, with ports in this order:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
REQ-006 The block SHALL have these remaining ports:
- play  in  1  start pulse
- stop  in  1  abort pulse
- repeat_en  in  1  loop at end when 1
- img_size  in  32  track length in bytes
- loop_word  in  32  loop point as a word index
- sd_ack  in  1  high for the duration of a sector transfer
- sd_buff_wr  in  1  word strobe
- sd_buff_dout  in  16  word data
- fifo_usedw  in  USEDW_W  FIFO fill level
- sd_rd  out  1  sector request
- sd_lba  out  LBA_W  sector address
- fifo_wr  out  1  FIFO write strobe
- fifo_data  out  16  FIFO write data
- playing  out  1  playback active
- looped  out  1  one-cycle loop pulse
- done  out  1  one-cycle end pulse

Function
REQ-007 Arithmetic SHALL be: total_words = img_size>>1, with an odd byte ignored; end_lba = (total_words-1)>>SECT_LOG2; end_off = (total_words-1) & mask, where mask = 2^SECT_LOG2-1.
REQ-008 For looping, loop_lba SHALL be loop_word>>SECT_LOG2 and loop_off SHALL be loop_word & mask; when loop_word >= total_words, both SHALL be 0.
REQ-009 All arithmetic SHALL be sampled on the accepted play and held until the next play.
REQ-010 The block SHALL use states IDLE, REQ, XFER, NEXT, END, DRAIN, encoded in registers.
REQ-011 IDLE: on play with total_words >= 1, the block SHALL set sd_lba=0, start_off=0, playing=1 and go to REQ.
REQ-012 IDLE: on play with total_words = 0, the block SHALL pulse done and stay in IDLE.
REQ-013 REQ: sd_rd SHALL assert the cycle after entry only while fifo_usedw < HIGH_MARK, hold until sd_ack is sampled high, deassert the following cycle, and the block SHALL then enter XFER.
REQ-014 XFER: the word counter SHALL reset to 0 at XFER entry and increment on each sd_buff_wr while sd_ack is high.
REQ-015 XFER: a word SHALL be forwarded when start_off <= index <= stop_off, where stop_off = end_off if sd_lba == end_lba, else mask.
REQ-016 fifo_wr and fifo_data SHALL be registered, one cycle after the accepted sd_buff_wr.
REQ-017 XFER SHALL exit to NEXT on the cycle sd_ack is sampled low; words arriving after the counter saturates at mask SHALL be ignored.
REQ-018 NEXT: if sd_lba < end_lba, the block SHALL increment sd_lba, set start_off=0 and go to REQ; otherwise it SHALL go to END.
REQ-019 END with repeat_en=1: the block SHALL set sd_lba=loop_lba, start_off=loop_off, pulse looped and go to REQ.
REQ-020 END with repeat_en=0: the block SHALL pulse done, clear playing, set sd_lba=0 and go to IDLE.
REQ-021 stop in REQ before ack SHALL drop sd_rd and clear playing, going to IDLE next cycle.
REQ-022 stop in XFER SHALL go to DRAIN: no further fifo_wr, remaining words are consumed, and on sd_ack low the block goes to IDLE with playing=0.
REQ-023 play while not IDLE SHALL act as stop followed by a restart at lba 0 once IDLE is reached; play and stop in the same cycle SHALL be treated as stop only.
REQ-024 looped and done SHALL never assert in the same cycle.

Reset
REQ-025 On reset assertion, immediately and asynchronously: state=IDLE; sd_rd, fifo_wr, playing, looped, done = 0; sd_lba, fifo_data, word counter, start_off = 0.
REQ-026 Reset asserted during a transfer SHALL abandon that transfer without further FIFO writes.

Verification
REQ-027 img_size=1024, repeat_en=0: the bench SHALL check requests at lba 0 then 1, 512 fifo_wr, done pulse once, playing=0.
REQ-028 img_size=1028: the bench SHALL check 3 sectors, the third forwarding words 0-1 only, 514 fifo_wr in total.
REQ-029 img_size=1024, repeat_en=1, loop_word=300: after lba 1, the bench SHALL check a looped pulse, sd_lba=1, words 0-43 skipped, then 212 fifo_wr.
REQ-030 fifo_usedw=1792 in REQ: the bench SHALL check sd_rd stays 0; usedw=1791 SHALL give sd_rd=1 on the next cycle.
REQ-031 stop at word 100 of sector 0: the bench SHALL check fifo_wr=0 thereafter, that sd_ack falling leads to IDLE, playing=0, and no done pulse.
REQ-032 reset pulse mid-XFER: the bench SHALL check all outputs are 0 within the same cycle and that a subsequent play restarts at lba 0.
